reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry × 32-bit integer register file for the RISC-V CPU core datapath (decode/writeback stages).
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- Synchronous active-high reset clears all registers.

Parameters:
- DWIDTH, 32, data width of each register and of wd/rd1/rd2.
- AWIDTH, 5, address width; number of registers = 2**AWIDTH (32).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- we  input  1  write enable
- ra1  input  AWIDTH  read address, port 1
- ra2  input  AWIDTH  read address, port 2
- wa  input  AWIDTH  write address
- wd  input  DWIDTH  write data
- rd1  output  DWIDTH  read data, port 1 (combinational from ra1)
- rd2  output  DWIDTH  read data, port 2 (combinational from ra2)

Behaviour:
- Storage: registers x1..x(2**AWIDTH-1), DWIDTH bits each. x0 has no storage.
- Write: at rising clk, if rst=0, we=1 and wa≠0, then reg[wa] <= wd.
  - Writes to wa=0 are discarded.
  - we=0 leaves all state unchanged.
- Reset: at rising clk with rst=1, all registers become 0.
  - Reset has priority over a simultaneous write; the write is dropped.
  - Reset asserted mid-sequence clears everything on that edge.
- Read: rdN = 0 when raN=0; otherwise rdN = reg[raN].
  - Purely combinational; zero cycle latency.
  - A value written at edge t is visible on rdN immediately after edge t, within the same delta/settling time.
- Read/write same address, same cycle:
  - Before the edge, rdN shows the old value.
  - After the edge, rdN shows the new value.
  - No internal write-to-read bypass; forwarding is the pipeline's job.
- Both read ports are independent and may address the same or different registers, including both reading the register being written.
- Outputs after reset: rd1 = rd2 = 0 for any address.
- Power-up without reset: contents undefined; x0 still reads 0.
- No handshakes, no stalls; every cycle accepts a write when we=1.

Decomposition:
- Shared core package holds:
  - XLEN=32
  - REG_ADDR_W=5
  - NUM_REGS=32
  - REG_ZERO=5'd0
- Width parameters default to these package constants.
- No sub-module; a single module with a register array and two read muxes.

Test Plan:
- Zero register: we=1, wa=0, wd=32'hFFFFFFFF, clock; ra1=ra2=0 -> rd1=rd2=32'h00000000.
- Write/immediate read: for i=1..31, we=1, wa=ra1=ra2=i, wd={4{i[7:0]}} (e.g. i=5 -> 32'h05050505); immediately after the edge -> rd1=rd2=wd.
- Hold with we=0: for i=0..31, ra1=ra2=i, wa=i, wd=random -> rd1=rd2={4{i[7:0]}} (x0 reads 0), contents unchanged. Negative check: rdN ≠ ~{4{i[7:0]}}.
- Independent ports: ra1=3, ra2=30 -> rd1=32'h03030303, rd2=32'h1E1E1E1E. Swap addresses -> values swap.
- Same-cycle read/write: reg[7]=32'h07070707; set wa=ra1=7, wd=32'hDEADBEEF, we=1.
  - Before the edge: rd1=32'h07070707.
  - After the edge: rd1=32'hDEADBEEF.
- Reset priority: rst=1 and we=1, wa=9, wd=32'h12345678, clock -> all reads 0, including ra=9. Deassert rst, write x9 -> reads back 32'h12345678.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared core constants for the integer register file.
// Width parameters of reg_file default to these values.
package reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// 32 x 32 integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, synchronous reset.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DWIDTH = XLEN,
  parameter int AWIDTH = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2
);

  localparam int NREGS = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(REG_ZERO);

  // No storage for x0; entries start at index 1.
  logic [DWIDTH-1:0] regs [1:NREGS-1];

  // Reset wins over a simultaneous write; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != ZERO_ADDR)) begin
      regs[wa] <= wd;
    end
  end

  // No write-to-read bypass: same-cycle reads see the pre-edge value.
  always_comb begin
    rd1 = '0;
    if (ra1 != ZERO_ADDR) begin
      rd1 = regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != ZERO_ADDR) begin
      rd2 = regs[ra2];
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table for read-port pairs plus
// hand-written sequences for write, hold, same-cycle and reset cases.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t vecs[6];

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .ra1 (ra1),
    .ra2 (ra2),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a_w,
                       input logic [DW-1:0] d, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    we  = w;
    wa  = a_w;
    wd  = d;
    ra1 = a1;
    ra2 = a2;
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {4{b}};
  endfunction

  initial begin
    logic [DW-1:0] e;

    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    tick();
    tick();

    // Reset state across a few addresses
    drive(1'b0, '0, '0, 5'd0, 5'd5);
    check("rst_rd1_x0", rd1, 32'h0);
    check("rst_rd2_x5", rd2, 32'h0);
    drive(1'b0, '0, '0, 5'd31, 5'd17);
    check("rst_rd1_x31", rd1, 32'h0);
    check("rst_rd2_x17", rd2, 32'h0);
    rst = 1'b0;

    // Write to x0 is discarded
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    tick();
    check("x0_rd1", rd1, 32'h0);
    check("x0_rd2", rd2, 32'h0);

    // Write every register, read back right after the edge
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, AW'(i), pat(i), AW'(i), AW'(i));
      exp_q.push_back(pat(i));
      tick();
      e = exp_q.pop_front();
      check($sformatf("wr_rd1_x%0d", i), rd1, e);
      check($sformatf("wr_rd2_x%0d", i), rd2, e);
    end

    // we=0 with random data leaves contents alone
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, AW'(i), DW'($urandom), AW'(i), AW'(i));
      exp_q.push_back((i == 0) ? 32'h0 : pat(i));
      tick();
      e = exp_q.pop_front();
      check($sformatf("hold_rd1_x%0d", i), rd1, e);
      check($sformatf("hold_rd2_x%0d", i), rd2, e);
      n_cmp++;
      if (i != 0 && rd1 === ~pat(i)) begin
        n_err++;
        $display("FAIL hold_neg_x%0d: got %h which must differ from %h", i, rd1, ~pat(i));
      end
    end

    // Independent read ports
    vecs[0] = '{ra1: 5'd3,  ra2: 5'd30, exp1: 32'h0303_0303, exp2: 32'h1E1E_1E1E};
    vecs[1] = '{ra1: 5'd30, ra2: 5'd3,  exp1: 32'h1E1E_1E1E, exp2: 32'h0303_0303};
    vecs[2] = '{ra1: 5'd0,  ra2: 5'd31, exp1: 32'h0000_0000, exp2: 32'h1F1F_1F1F};
    vecs[3] = '{ra1: 5'd31, ra2: 5'd0,  exp1: 32'h1F1F_1F1F, exp2: 32'h0000_0000};
    vecs[4] = '{ra1: 5'd16, ra2: 5'd16, exp1: 32'h1010_1010, exp2: 32'h1010_1010};
    vecs[5] = '{ra1: 5'd1,  ra2: 5'd10, exp1: 32'h0101_0101, exp2: 32'h0A0A_0A0A};
    for (int v = 0; v < 6; v++) begin
      drive(1'b0, '0, '0, vecs[v].ra1, vecs[v].ra2);
      check($sformatf("vec%0d_rd1", v), rd1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), rd2, vecs[v].exp2);
    end

    // Same-cycle read/write of x7: old before edge, new after
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
    check("rw_before_rd1", rd1, 32'h0707_0707);
    check("rw_before_rd2", rd2, 32'h0707_0707);
    tick();
    check("rw_after_rd1", rd1, 32'hDEAD_BEEF);
    check("rw_after_rd2", rd2, 32'hDEAD_BEEF);

    // Reset beats a simultaneous write
    rst = 1'b1;
    drive(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd7);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, '0, '0, AW'(i), AW'(31 - i));
      check($sformatf("rstpri_rd1_x%0d", i), rd1, 32'h0);
      check($sformatf("rstpri_rd2_x%0d", 31 - i), rd2, 32'h0);
    end

    drive(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd8);
    tick();
    drive(1'b0, '0, '0, 5'd9, 5'd8);
    check("post_rst_x9", rd1, 32'h1234_5678);
    check("post_rst_x8", rd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_file
